// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- decode-stage control, hazard stall and branch flush sequencer
//
// Decodes the instruction sitting in decode into the datapath control bundle,
// tracks in-flight register writes in a three-entry scoreboard (EX, MEM, WB)
// and stalls fetch on read-after-write hazards against EX or MEM. A taken
// branch from execute flushes decode/execute for one cycle. A small sequencer
// walks RESET -> FILL -> RUN -> DRAIN -> HALT.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous active-low reset
//   opfn[4:0]            opcode/function of the decode instruction
//   ra, rb, rd[2:0]      source A, source B, destination register fields
//   alubeq               branch taken, from execute
//   NIA                  next-instruction-address select (jump)
//   RegDst .. MemToReg   decode control bundle
//   ALUFn[2:0]           ALU function select
//   pc_en, ir_en         PC / instruction register load enables
//   flush                squash decode and execute
//   halted               high in HALT
//   stall_cnt, flush_cnt saturating event counters
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opfn,
    input  logic [2:0]       ra,
    input  logic [2:0]       rb,
    input  logic [2:0]       rd,
    input  logic             alubeq,
    output logic             NIA,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemToReg,
    output logic [2:0]       ALUFn,
    output logic             pc_en,
    output logic             ir_en,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] OpAdd  = 5'b00000;
    localparam logic [4:0] OpSub  = 5'b00001;
    localparam logic [4:0] OpAnd  = 5'b00010;
    localparam logic [4:0] OpOr   = 5'b00011;
    localparam logic [4:0] OpAddi = 5'b01000;
    localparam logic [4:0] OpLw   = 5'b01001;
    localparam logic [4:0] OpSw   = 5'b01010;
    localparam logic [4:0] OpBeq  = 5'b01011;
    localparam logic [4:0] OpJ    = 5'b10000;
    localparam logic [4:0] OpHalt = 5'b11111;

    typedef enum logic [2:0] {
        StReset,
        StFill,
        StRun,
        StDrain,
        StHalt
    } state_e;

    state_e     state_q;
    logic [1:0] phase_cnt_q;   // shared FILL / DRAIN cycle counter

    // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]      sb_valid_q;
    logic [2:0][2:0] sb_dest_q;
    logic [2:0]      sb_load_q;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Raw decode of opfn, before stall/flush gating
    logic       dec_nia;
    logic       dec_reg_dst;
    logic       dec_reg_write;
    logic       dec_alu_src;
    logic       dec_mem_write;
    logic       dec_mem_read;
    logic       dec_mem_to_reg;
    logic [2:0] dec_alu_fn;
    logic       dec_halt;
    logic       uses_rb;

    logic       hit_a;
    logic       hit_b;
    logic       hazard;
    logic       in_run;
    logic       stall_evt;
    logic       flush_evt;
    logic       halt_go;
    logic [2:0] ex_dest;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_nia        = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_fn     = 3'b000;
        dec_halt       = 1'b0;
        uses_rb        = 1'b0;
        case (opfn)
            OpAdd: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                uses_rb       = 1'b1;
            end
            OpSub: begin
                dec_alu_fn    = 3'b001;
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                uses_rb       = 1'b1;
            end
            OpAnd: begin
                dec_alu_fn    = 3'b010;
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                uses_rb       = 1'b1;
            end
            OpOr: begin
                dec_alu_fn    = 3'b011;
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                uses_rb       = 1'b1;
            end
            OpAddi: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpLw: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
            end
            OpSw: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                uses_rb       = 1'b1;
            end
            OpBeq: begin
                dec_alu_fn = 3'b001;
                uses_rb    = 1'b1;
            end
            OpJ:     dec_nia  = 1'b1;
            OpHalt:  dec_halt = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // RAW hazard against EX and MEM; r0 is hardwired and never conflicts
    // ------------------------------------------------------------------
    assign hit_a = (ra != 3'd0) &&
                   ((sb_valid_q[0] && (sb_dest_q[0] == ra)) ||
                    (sb_valid_q[1] && (sb_dest_q[1] == ra)));
    assign hit_b = uses_rb && (rb != 3'd0) &&
                   ((sb_valid_q[0] && (sb_dest_q[0] == rb)) ||
                    (sb_valid_q[1] && (sb_dest_q[1] == rb)));
    assign hazard = hit_a || hit_b;

    // A taken branch overrides a stall in the same cycle
    assign in_run    = (state_q == StRun);
    assign flush_evt = in_run && alubeq;
    assign stall_evt = in_run && !alubeq && hazard;
    assign halt_go   = in_run && !alubeq && !hazard && dec_halt;

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    always_comb begin
        NIA      = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        MemToReg = 1'b0;
        ALUFn    = 3'b000;
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        flush    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            StFill: begin
                pc_en = 1'b1;
                ir_en = 1'b1;
            end
            StRun: begin
                if (alubeq) begin
                    flush = 1'b1;
                    pc_en = 1'b1;
                    ir_en = 1'b1;
                end else if (!hazard) begin
                    NIA      = dec_nia;
                    RegDst   = dec_reg_dst;
                    RegWrite = dec_reg_write;
                    ALUSrc   = dec_alu_src;
                    MemWrite = dec_mem_write;
                    MemRead  = dec_mem_read;
                    MemToReg = dec_mem_to_reg;
                    ALUFn    = dec_alu_fn;
                    pc_en    = 1'b1;
                    ir_en    = 1'b1;
                end
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StReset;
            phase_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                StReset: begin
                    state_q     <= StFill;
                    phase_cnt_q <= 2'd0;
                end
                StFill: begin
                    if (phase_cnt_q == 2'd2) begin
                        state_q     <= StRun;
                        phase_cnt_q <= 2'd0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 2'd1;
                    end
                end
                StRun: begin
                    if (halt_go) begin
                        state_q     <= StDrain;
                        phase_cnt_q <= 2'd0;
                    end
                end
                StDrain: begin
                    // alubeq is deliberately not looked at here
                    if (phase_cnt_q == 2'd2) begin
                        state_q     <= StHalt;
                        phase_cnt_q <= 2'd0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 2'd1;
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StReset;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard shift; gated controls mean bubbles and flushes enter
    // EX as invalid entries without extra logic.
    // ------------------------------------------------------------------
    assign ex_dest = RegDst ? rd : rb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid_q <= '0;
            sb_dest_q  <= '0;
            sb_load_q  <= '0;
        end else begin
            sb_valid_q <= {sb_valid_q[1:0], RegWrite};
            sb_dest_q  <= {sb_dest_q[1:0], ex_dest};
            sb_load_q  <= {sb_load_q[1:0], MemRead};
        end
    end

    // WB entry and load flags are carried for downstream use only
    logic sb_unused;
    assign sb_unused = ^{sb_valid_q[2], sb_dest_q[2], sb_load_q};

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
